// File: rtl/numarator_ctr.sv
// Modulo-MODULUS counter with a one-cycle wrap carry for chaining timer stages.
// Optional down-counting (input numara_jos) is enabled by defining NUMARATOR_DOWN_EN.
module numarator_ctr #(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 60
) (
    input  logic             clk_out_led,
    input  logic             reset,
    input  logic             pauza,
`ifdef NUMARATOR_DOWN_EN
    input  logic             numara_jos,
`endif
    output logic [WIDTH-1:0] valoarea_bin,
    output logic             carry_out
);

    // MODULUS may equal 2**WIDTH, so only MODULUS-1 is guaranteed to fit in WIDTH bits.
    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             count_down;

`ifdef NUMARATOR_DOWN_EN
    assign count_down = numara_jos;
`else
    assign count_down = 1'b0;
`endif

    // NOTE: defaults at the top of always_comb keep every path assigned, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (!pauza) begin
            if (count_q > TERMINAL) begin
                count_d = '0;
            end else if (count_down) begin
                if (count_q == '0) begin
                    count_d = TERMINAL;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end else begin
                if (count_q == TERMINAL) begin
                    count_d = '0;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_out_led or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    assign valoarea_bin = count_q;
    assign carry_out    = carry_q;

endmodule

// File: tb/tb_numarator_ctr.sv
// Scoreboard bench for numarator_ctr: expectations are queued as each edge is driven.
module tb_numarator_ctr;

    localparam int WIDTH   = 6;
    localparam int MODULUS = 60;

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             carry;
    } exp_t;

    logic             clk_out_led = 1'b0;
    logic             reset       = 1'b1;
    logic             pauza       = 1'b0;
`ifdef NUMARATOR_DOWN_EN
    logic             numara_jos  = 1'b0;
`endif
    logic [WIDTH-1:0] valoarea_bin;
    logic             carry_out;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] m_cnt = '0;
    int               n_checks = 0;
    int               n_fail   = 0;

    numarator_ctr #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk_out_led  (clk_out_led),
        .reset        (reset),
        .pauza        (pauza),
`ifdef NUMARATOR_DOWN_EN
        .numara_jos   (numara_jos),
`endif
        .valoarea_bin (valoarea_bin),
        .carry_out    (carry_out)
    );

    always #5 clk_out_led = ~clk_out_led;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Drive inputs for one edge, queue the expected result, then advance past the edge.
    task automatic drive_edge(input logic p, input logic dn);
        exp_t e;
        e.carry = 1'b0;
        if (p) begin
            e.val = m_cnt;
        end else if (dn) begin
            if (m_cnt == '0) begin
                e.val   = WIDTH'(MODULUS - 1);
                e.carry = 1'b1;
            end else begin
                e.val = m_cnt - WIDTH'(1);
            end
        end else if (m_cnt == WIDTH'(MODULUS - 1)) begin
            e.val   = '0;
            e.carry = 1'b1;
        end else begin
            e.val = m_cnt + WIDTH'(1);
        end
        m_cnt = e.val;
        pauza = p;
`ifdef NUMARATOR_DOWN_EN
        numara_jos = dn;
`endif
        sb_q.push_back(e);
        @(posedge clk_out_led);
        #1;
    endtask

    // Short asynchronous pulse placed between edges; returns the model to zero.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_cnt = '0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pauza = 1'b0;
        repeat (3) @(posedge clk_out_led);
        #1;
        n_checks++;
        if (valoarea_bin !== '0) begin
            n_fail++;
            $display("FAIL reset_val: got %0d expected 0", valoarea_bin);
        end
        n_checks++;
        if (carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_carry: got %b expected 0", carry_out);
        end
        reset = 1'b0;
        m_cnt = '0;
    endtask

    task automatic test_count();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            drive_edge(1'b0, 1'b0);
            e = sb_q.pop_front();
            n_checks++;
            if (valoarea_bin !== e.val || carry_out !== e.carry) begin
                n_fail++;
                $display("FAIL count[%0d]: got %0d/%b expected %0d/%b", i, valoarea_bin, carry_out, e.val, e.carry);
            end
        end
        n_checks++;
        if (valoarea_bin !== 6'd10) begin
            n_fail++;
            $display("FAIL count_after_10: got %0d expected 10", valoarea_bin);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        pulse_reset();
        for (int i = 1; i <= 61; i++) begin
            drive_edge(1'b0, 1'b0);
            e = sb_q.pop_front();
            n_checks++;
            if (valoarea_bin !== e.val || carry_out !== e.carry) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %0d/%b expected %0d/%b", i, valoarea_bin, carry_out, e.val, e.carry);
            end
            if (i == 59) begin
                n_checks++;
                if (valoarea_bin !== 6'd59 || carry_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_top: got %0d/%b expected 59/0", valoarea_bin, carry_out);
                end
            end else if (i == 60) begin
                n_checks++;
                if (valoarea_bin !== 6'd0 || carry_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_edge: got %0d/%b expected 0/1", valoarea_bin, carry_out);
                end
            end else if (i == 61) begin
                n_checks++;
                if (valoarea_bin !== 6'd1 || carry_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_after: got %0d/%b expected 1/0", valoarea_bin, carry_out);
                end
            end
        end
    endtask

    task automatic test_pause();
        exp_t e;
        pulse_reset();
        repeat (5) begin
            drive_edge(1'b0, 1'b0);
            void'(sb_q.pop_front());
        end
        for (int i = 0; i < 10; i++) begin
            drive_edge(1'b1, 1'b0);
            e = sb_q.pop_front();
            n_checks++;
            if (valoarea_bin !== 6'd5 || carry_out !== 1'b0 || valoarea_bin !== e.val) begin
                n_fail++;
                $display("FAIL pause_hold[%0d]: got %0d/%b expected 5/0", i, valoarea_bin, carry_out);
            end
        end
        drive_edge(1'b0, 1'b0);
        e = sb_q.pop_front();
        n_checks++;
        if (valoarea_bin !== 6'd6 || carry_out !== e.carry) begin
            n_fail++;
            $display("FAIL pause_release: got %0d/%b expected 6/0", valoarea_bin, carry_out);
        end
    endtask

    task automatic test_pause_at_top();
        exp_t e;
        pulse_reset();
        repeat (59) begin
            drive_edge(1'b0, 1'b0);
            void'(sb_q.pop_front());
        end
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b1, 1'b0);
            e = sb_q.pop_front();
            n_checks++;
            if (valoarea_bin !== 6'd59 || carry_out !== 1'b0 || valoarea_bin !== e.val) begin
                n_fail++;
                $display("FAIL pause_top_hold[%0d]: got %0d/%b expected 59/0", i, valoarea_bin, carry_out);
            end
        end
        drive_edge(1'b0, 1'b0);
        e = sb_q.pop_front();
        n_checks++;
        if (valoarea_bin !== 6'd0 || carry_out !== 1'b1 || e.carry !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_top_wrap: got %0d/%b expected 0/1", valoarea_bin, carry_out);
        end
        // A carry that is pending when pause arrives must clear, not stretch.
        drive_edge(1'b1, 1'b0);
        e = sb_q.pop_front();
        n_checks++;
        if (valoarea_bin !== 6'd0 || carry_out !== 1'b0 || e.carry !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_clears_carry: got %0d/%b expected 0/0", valoarea_bin, carry_out);
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        repeat (17) begin
            drive_edge(1'b0, 1'b0);
            void'(sb_q.pop_front());
        end
        n_checks++;
        if (valoarea_bin !== 6'd17) begin
            n_fail++;
            $display("FAIL mid_pre: got %0d expected 17", valoarea_bin);
        end
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (valoarea_bin !== '0 || carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got %0d/%b expected 0/0", valoarea_bin, carry_out);
        end
        @(posedge clk_out_led);
        #1;
        n_checks++;
        if (valoarea_bin !== '0 || carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_held: got %0d/%b expected 0/0", valoarea_bin, carry_out);
        end
        reset = 1'b0;
        m_cnt = '0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic p;
        pulse_reset();
        for (int i = 0; i < 150; i++) begin
            p = ($urandom_range(0, 3) == 0);
            drive_edge(p, 1'b0);
            e = sb_q.pop_front();
            n_checks++;
            if (valoarea_bin !== e.val || carry_out !== e.carry) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %0d/%b expected %0d/%b", i, valoarea_bin, carry_out, e.val, e.carry);
            end
        end
    endtask

`ifdef NUMARATOR_DOWN_EN
    task automatic test_down();
        exp_t e;
        logic [WIDTH-1:0] want_v[4];
        logic             want_c[4];
        logic             dir[4];
        want_v = '{6'd59, 6'd58, 6'd57, 6'd58};
        want_c = '{1'b1, 1'b0, 1'b0, 1'b0};
        dir    = '{1'b1, 1'b1, 1'b1, 1'b0};
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            drive_edge(1'b0, dir[i]);
            e = sb_q.pop_front();
            n_checks++;
            if (valoarea_bin !== want_v[i] || carry_out !== want_c[i] || e.val !== want_v[i]) begin
                n_fail++;
                $display("FAIL down[%0d]: got %0d/%b expected %0d/%b", i, valoarea_bin, carry_out, want_v[i], want_c[i]);
            end
        end
        for (int i = 0; i < 100; i++) begin
            drive_edge(($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1);
            e = sb_q.pop_front();
            n_checks++;
            if (valoarea_bin !== e.val || carry_out !== e.carry) begin
                n_fail++;
                $display("FAIL down_mix[%0d]: got %0d/%b expected %0d/%b", i, valoarea_bin, carry_out, e.val, e.carry);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_pause_at_top();
        test_reset_mid();
        test_back_to_back();
`ifdef NUMARATOR_DOWN_EN
        test_down();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/numarator_ctr.md
Name: numarator_ctr

Overview:
- Modulo-N up-counter (default mod-60, seconds/minutes digit pair) for the timer datapath, clocked by the divided LED/tick clock.
- Outputs the current count in binary and a one-cycle carry pulse on wrap, which chains to the next timer stage.
- The count can be frozen by a pause input.

Parameters:
- WIDTH, 6, bit width of valoarea_bin; must satisfy 2**WIDTH >= MODULUS.
- MODULUS, 60, count range 0..MODULUS-1; legal range 2..2**WIDTH.

Ports:
- clk_out_led  input  1  tick clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pauza  input  1  pause; 1 = hold the count, 0 = count.
- valoarea_bin  output  WIDTH  current count, registered.
- carry_out  output  1  registered wrap pulse to the next stage.
- numara_jos  input  1  count direction; present only with NUMARATOR_DOWN_EN.

Behaviour:
- Interface: one clock (clk_out_led); reset is asynchronous and active-high (reset).
- Reset asserted: valoarea_bin=0 and carry_out=0 immediately, without waiting for a clock edge. Held while reset=1; reset overrides pauza and every other input.
- Reset release: the first rising edge with reset=0 is evaluated normally. No extra latency.
- Rising edge, reset=0, pauza=0:
  - If valoarea_bin < MODULUS-1: valoarea_bin+1, carry_out=0.
  - If valoarea_bin == MODULUS-1: valoarea_bin=0, carry_out=1.
- carry_out is therefore high for exactly one clock period, coincident with the count showing 0 after a wrap.
- Rising edge, reset=0, pauza=1: valoarea_bin holds its value; carry_out=0.
  - A pending carry is cleared on the next edge, never stretched.
  - No carry is generated while paused.
- Pause released while count == MODULUS-1: the next edge wraps and pulses carry as normal.
- Out-of-range count (>= MODULUS, reachable only by X/SEU): the next counting edge forces valoarea_bin=0 and carry_out=0.
- Arithmetic is unsigned WIDTH-bit; the terminal-count compare uses MODULUS-1 only, never relying on natural 2**WIDTH overflow.
- Reset mid-count: immediate clear, with no carry emitted.
- No combinational path from any input to any output; both outputs come straight from flops.

Optional Feature:
- Macro NUMARATOR_DOWN_EN.
- Defined: adds input numara_jos.
  - numara_jos=1 counts down: MODULUS-1 ... 0. Stepping 0 -> MODULUS-1 pulses carry_out (borrow) for one cycle.
  - numara_jos=0 behaves exactly as the undefined case.
  - Direction is sampled each edge and may change between edges. Pause and reset rules are unchanged.
- Undefined: port absent, up-count only.

Test Plan:
- Reset: reset=1 at t=0 with clock running (10 ns period) -> valoarea_bin=0, carry_out=0. Assert reset mid-cycle at count 17 -> outputs go to 0 before the next edge.
- Counting: reset released, pauza=0, 10 edges -> valoarea_bin=10, carry_out=0 throughout.
- Wrap: count from 0 for 60 edges -> valoarea_bin 59 then 0 on the 60th edge. carry_out=1 only in the cycle where the value is 0, then 0 on the next edge (value 1).
- Pause: pauza=1 at count 5 for 10 edges -> stays 5, carry_out=0. Release -> 6 on the next edge.
- Pause at 59: pause for 3 edges (holds 59, carry 0), release -> next edge gives 0 with carry_out=1.
- NUMARATOR_DOWN_EN: numara_jos=1 from reset -> 59 with carry_out=1 on the first edge, then 58, 57. Switching to numara_jos=0 at 57 -> 58 on the next edge.
